// File: rtl/dano_frota_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : dano_frota_if                                         |
// | Brief    : Shot-result request / fleet write-back bundle between |
// |            the turn controller, collision checker and dano_frota |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
interface dano_frota_if #(
   parameter int ADDR_W = 5
) ();
   // request side (turn controller + collision checker)
   logic              start;
   logic              hit;
   logic              jogador;
   logic [ADDR_W-1:0] addr;
   logic [63:0]       clear;
   // fleet memory write port and status
   logic              wrep1;
   logic              wrep2;
   logic [ADDR_W-1:0] wr_addr;
   logic [63:0]       wr_data;
   logic              busy;
   logic              done;
   logic [1:0]        result;
   logic [3:0]        afundados_p1;
   logic [3:0]        afundados_p2;
   logic              game_over;
   logic              perdedor;
   logic              erro;

   modport master (
      output start, hit, jogador, addr, clear,
      input  wrep1, wrep2, wr_addr, wr_data, busy, done, result,
             afundados_p1, afundados_p2, game_over, perdedor, erro
   );

   modport slave (
      input  start, hit, jogador, addr, clear,
      output wrep1, wrep2, wr_addr, wr_data, busy, done, result,
             afundados_p1, afundados_p2, game_over, perdedor, erro
   );
endinterface
`default_nettype wire

// File: rtl/dano_frota.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : dano_frota                                            |
// | Brief    : Read-modify-write of a struck ship record: decrements |
// |            remaining pieces, writes the record back to the       |
// |            struck player's fleet memory, counts sunk ships and   |
// |            latches game over.                                    |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
module dano_frota #(
   parameter int NUM_SHIPS = 5,
   parameter int ADDR_W    = 5
) (
   input  wire logic    clk,
   input  wire logic    rst,
   dano_frota_if.slave  bus
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_CHECK = 2'd1,
      S_WRITE = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic [31:0] c_num_ships_w = NUM_SHIPS;
   localparam logic [3:0]  c_num_ships   = c_num_ships_w[3:0];

   state_t            r_state;
   state_t            w_next;

   // shot snapshot taken at the accepting edge
   logic              r_hit;
   logic              r_jog;
   logic [ADDR_W-1:0] r_addr;
   logic [47:0]       r_clear;

   logic [3:0]        r_sunk_p1;
   logic [3:0]        r_sunk_p2;
   logic              r_game_over;

   logic              w_accept;
   logic [2:0]        w_pieces;
   logic [2:0]        w_new_pieces;
   logic              w_illegal;
   logic [3:0]        w_sunk_cur;
   logic [3:0]        w_sunk_inc;
   logic [63:0]       w_wdata;

   assign w_accept     = (r_state == S_IDLE) && bus.start && !r_game_over;
   assign w_pieces     = r_clear[47:45];
   assign w_new_pieces = w_pieces - 3'd1;
   assign w_illegal    = ({{(32-ADDR_W){1'b0}}, r_addr} >= c_num_ships_w) ||
                         (w_pieces == 3'd0);
   assign w_sunk_cur   = r_jog ? r_sunk_p2 : r_sunk_p1;
   // saturate so a counter can never wrap past the fleet size
   assign w_sunk_inc   = (w_sunk_cur < c_num_ships) ? (w_sunk_cur + 4'd1) : w_sunk_cur;
   // upper bits forced to zero; the slots keep the already-cleared hit coordinate
   assign w_wdata      = {16'h0000, w_new_pieces, r_clear[44:0]};

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   // next-state decode
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_accept) w_next = S_CHECK;
         S_CHECK: w_next = (r_hit && !w_illegal) ? S_WRITE : S_DONE;
         S_WRITE: w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // shot capture, write-back port, outcome and sunk bookkeeping
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_hit            <= 1'b0;
         r_jog            <= 1'b0;
         r_addr           <= '0;
         r_clear          <= '0;
         r_sunk_p1        <= 4'd0;
         r_sunk_p2        <= 4'd0;
         r_game_over      <= 1'b0;
         bus.wrep1        <= 1'b0;
         bus.wrep2        <= 1'b0;
         bus.wr_addr      <= '0;
         bus.wr_data      <= '0;
         bus.result       <= 2'b00;
         bus.perdedor     <= 1'b0;
         bus.erro         <= 1'b0;
      end else begin
         bus.wrep1 <= 1'b0;
         bus.wrep2 <= 1'b0;
         bus.erro  <= 1'b0;
         if (w_accept) begin
            r_hit   <= bus.hit;
            r_jog   <= bus.jogador;
            r_addr  <= bus.addr;
            r_clear <= bus.clear[47:0];
         end
         case (r_state)
            S_CHECK: begin
               if (!r_hit) begin
                  bus.result <= 2'b00;
               end else if (w_illegal) begin
                  bus.result <= 2'b00;
                  bus.erro   <= 1'b1;
               end else begin
                  bus.wr_addr <= r_addr;
                  bus.wr_data <= w_wdata;
                  bus.wrep1   <= !r_jog;
                  bus.wrep2   <= r_jog;
               end
            end
            S_WRITE: begin
               if (w_new_pieces == 3'd0) begin
                  if (r_jog) r_sunk_p2 <= w_sunk_inc;
                  else       r_sunk_p1 <= w_sunk_inc;
                  if (w_sunk_inc == c_num_ships) begin
                     r_game_over  <= 1'b1;
                     bus.perdedor <= r_jog;
                     bus.result   <= 2'b11;
                  end else begin
                     bus.result   <= 2'b10;
                  end
               end else begin
                  bus.result <= 2'b01;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.busy         = (r_state != S_IDLE);
   assign bus.done         = (r_state == S_DONE);
   assign bus.game_over    = r_game_over;
   assign bus.afundados_p1 = r_sunk_p1;
   assign bus.afundados_p2 = r_sunk_p2;

endmodule
`default_nettype wire
